// File: rtl/tnn_feature_packer.sv
// -----------------------------------------------------------------------------
// tnn_feature_packer
//
// Streaming front end for the 2-bit-input TNN classifier cores. Raw feature
// samples arrive one per beat, are quantized to 2 bits against per-feature
// programmable thresholds, and are packed N_FEAT at a time into one vector that
// is handed to the classifier over a valid/ready interface.
//
// Parameters
//   IN_W    raw feature width (unsigned)
//   N_FEAT  features per frame (1..8); feature k lands in m_data[2k+1:2k]
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   s_valid/s_ready raw beat handshake
//   s_data          raw feature value
//   s_last          marks the final feature of a frame
//   m_valid/m_ready packed vector handshake
//   m_data          packed quantized vector
//   cfg_we          threshold write strobe
//   cfg_feat        feature index for the write
//   cfg_sel         threshold index 0..2 (3 is ignored)
//   cfg_thr         threshold value
//   err             one-cycle framing-error pulse
//   stat_frames     frames delivered (saturating)
//   stat_errs       frames dropped (saturating)
//
// Build option
//   TNN_PACKER_STATS_EN  when defined, stat_frames/stat_errs are live counters;
//                        otherwise they are tied to zero and no logic is built.
// -----------------------------------------------------------------------------
module tnn_feature_packer #(
  parameter int IN_W   = 8,
  parameter int N_FEAT = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_W-1:0]       s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [2*N_FEAT-1:0]   m_data,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_feat,
  input  logic [1:0]            cfg_sel,
  input  logic [IN_W-1:0]       cfg_thr,
  output logic                  err,
  output logic [15:0]           stat_frames,
  output logic [15:0]           stat_errs
);

  localparam logic [2:0]      LAST_SLOT = 3'(N_FEAT - 1);
  localparam logic [IN_W-1:0] T0_RST    = IN_W'(1) << (IN_W - 2);
  localparam logic [IN_W-1:0] T1_RST    = IN_W'(1) << (IN_W - 1);
  localparam logic [IN_W-1:0] T2_RST    = T0_RST | T1_RST;

  // Threshold table: thr[feature][index]
  logic [IN_W-1:0]     thr [N_FEAT][3];

  logic [2:0]          cnt;
  logic [2*N_FEAT-1:0] acc;
  logic [2*N_FEAT-1:0] merged;

  logic [IN_W-1:0]     t0, t1, t2;
  logic [1:0]          q;

  logic                accept;
  logic                at_last;
  logic                close_frame;
  logic                frame_err;

  // ---------------------------------------------------------------------------
  // Handshake / framing decode
  // ---------------------------------------------------------------------------
  assign at_last = (cnt == LAST_SLOT);

  // Only the closing beat needs the output register, so only it stalls.
  assign s_ready     = !(at_last && m_valid && !m_ready);
  assign accept      = s_valid && s_ready;
  assign close_frame = accept && at_last && s_last;
  assign frame_err   = accept && (s_last != at_last);

  // ---------------------------------------------------------------------------
  // Quantizer: thresholds of the current slot, sum of three compares
  // ---------------------------------------------------------------------------
  always_comb begin
    t0 = '0;
    t1 = '0;
    t2 = '0;
    for (int unsigned k = 0; k < N_FEAT; k++) begin
      if (cnt == 3'(k)) begin
        t0 = thr[k][0];
        t1 = thr[k][1];
        t2 = thr[k][2];
      end
    end
  end

  // Non-monotonic thresholds are allowed; the plain sum is still the code.
  assign q = {1'b0, (s_data >= t0)} + {1'b0, (s_data >= t1)} + {1'b0, (s_data >= t2)};

  // Accumulator with the current beat merged into slot cnt
  always_comb begin
    merged = acc;
    for (int unsigned k = 0; k < N_FEAT; k++) begin
      if (cnt == 3'(k)) begin
        merged[2*k +: 2] = q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Threshold table
  // ---------------------------------------------------------------------------
  // Out-of-range feature indices and cfg_sel==3 match no entry and are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_FEAT; k++) begin
        thr[k][0] <= T0_RST;
        thr[k][1] <= T1_RST;
        thr[k][2] <= T2_RST;
      end
    end else if (cfg_we) begin
      for (int unsigned k = 0; k < N_FEAT; k++) begin
        for (int unsigned s = 0; s < 3; s++) begin
          if (cfg_feat == 3'(k) && cfg_sel == 2'(s)) begin
            thr[k][s] <= cfg_thr;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Collection side: slot counter and accumulator
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      err <= 1'b0;
    end else begin
      err <= 1'b0;
      if (accept) begin
        if (frame_err) begin
          cnt <= '0;
          acc <= '0;
          err <= 1'b1;
        end else if (close_frame) begin
          cnt <= '0;
          acc <= '0;
        end else begin
          cnt <= cnt + 3'd1;
          acc <= merged;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register (second buffer)
  // ---------------------------------------------------------------------------
  // close_frame can only occur when the register is empty or being drained in
  // the same cycle (s_ready guarantees it), so loading takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (close_frame) begin
      m_valid <= 1'b1;
      m_data  <= merged;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef TNN_PACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames <= '0;
      stat_errs   <= '0;
    end else begin
      if (m_valid && m_ready && stat_frames != '1) begin
        stat_frames <= stat_frames + 16'd1;
      end
      if (err && stat_errs != '1) begin
        stat_errs <= stat_errs + 16'd1;
      end
    end
  end
`else
  assign stat_frames = '0;
  assign stat_errs   = '0;
`endif

endmodule

// File: tb/tb_tnn_feature_packer.sv
module tb_tnn_feature_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [9:0]  m_data;
  logic        cfg_we;
  logic [2:0]  cfg_feat;
  logic [1:0]  cfg_sel;
  logic [7:0]  cfg_thr;
  logic        err;
  logic [15:0] stat_frames;
  logic [15:0] stat_errs;

  int total = 0;
  int bad   = 0;

  tnn_feature_packer #(.IN_W(8), .N_FEAT(5)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cfg_we(cfg_we), .cfg_feat(cfg_feat), .cfg_sel(cfg_sel), .cfg_thr(cfg_thr),
    .err(err), .stat_frames(stat_frames), .stat_errs(stat_errs)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send(input logic [7:0] d, input logic last);
    int guard;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    guard   = 0;
    #0;
    while (!s_ready && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) chk("send_timeout", 32'd1, 32'd0);
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send5(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] d, input logic [7:0] e);
    send(a, 1'b0);
    send(b, 1'b0);
    send(c, 1'b0);
    send(d, 1'b0);
    send(e, 1'b1);
  endtask

  task automatic cfg(input logic [2:0] f, input logic [1:0] s, input logic [7:0] v);
    cfg_we = 1'b1; cfg_feat = f; cfg_sel = s; cfg_thr = v;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    cfg_we = 1'b0; cfg_feat = '0; cfg_sel = '0; cfg_thr = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data",  32'(m_data),  32'h0);
    chk("rst_err",     32'(err),     32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);

    // Basic frame, default thresholds 64/128/192
    send5(8'd10, 8'd64, 8'd127, 8'd200, 8'd255);
    chk("f1_valid", 32'(m_valid), 32'd1);
    chk("f1_data",  32'(m_data),  32'h3D4);
    chk("f1_err",   32'(err),     32'd0);
    step();
    chk("f1_drain", 32'(m_valid), 32'd0);

    // Backpressure: output held, next frame's closing beat stalls
    m_ready = 1'b0;
    send5(8'd10, 8'd64, 8'd127, 8'd200, 8'd255);
    send(8'd0, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b0);
    chk("bp_hold_valid", 32'(m_valid), 32'd1);
    chk("bp_hold_data",  32'(m_data),  32'h3D4);
    s_valid = 1'b1; s_data = 8'd0; s_last = 1'b1;
    #0;
    chk("bp_stall", 32'(s_ready), 32'd0);
    step();
    chk("bp_stall2", 32'(s_ready), 32'd0);
    chk("bp_still_data", 32'(m_data), 32'h3D4);
    m_ready = 1'b1;
    #0;
    chk("bp_release", 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b0; s_last = 1'b0;
    chk("bp_f2_valid", 32'(m_valid), 32'd1);
    chk("bp_f2_data",  32'(m_data),  32'h000);
    step();
    chk("bp_f2_drain", 32'(m_valid), 32'd0);

    // Framing error: s_last on third beat
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b1);
    chk("ferr_pulse", 32'(err),     32'd1);
    chk("ferr_nov",   32'(m_valid), 32'd0);
    step();
    chk("ferr_clear", 32'(err),     32'd0);
    send5(8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    chk("ferr_next_valid", 32'(m_valid), 32'd1);
    chk("ferr_next_data",  32'(m_data),  32'h3FF);
    step();

    // Threshold writes
    cfg(3'd1, 2'd0, 8'd10);
    send5(8'd9, 8'd9, 8'd9, 8'd9, 8'd9);
    chk("cfg9", 32'(m_data), 32'h000);
    step();
    send5(8'd10, 8'd10, 8'd10, 8'd10, 8'd10);
    chk("cfg10", 32'(m_data), 32'h004);
    step();

    // Ignored writes
    cfg(3'd0, 2'd3, 8'd0);
    cfg(3'd7, 2'd0, 8'd0);
    send5(8'd64, 8'd64, 8'd64, 8'd64, 8'd64);
    chk("cfg_ignored", 32'(m_data), 32'h155);
    step();

    // Write in the same cycle as a beat uses the old value
    cfg_we = 1'b1; cfg_feat = 3'd0; cfg_sel = 2'd0; cfg_thr = 8'd5;
    send(8'd5, 1'b0);
    cfg_we = 1'b0;
    send(8'd5, 1'b0); send(8'd5, 1'b0); send(8'd5, 1'b0); send(8'd5, 1'b1);
    chk("cfg_same_cycle", 32'(m_data), 32'h000);
    step();
    send5(8'd5, 8'd5, 8'd5, 8'd5, 8'd5);
    chk("cfg_after", 32'(m_data), 32'h001);
    step();

    // Reset mid-frame: counter and thresholds restored
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rstmid_valid", 32'(m_valid), 32'd0);
    send5(8'd10, 8'd10, 8'd10, 8'd10, 8'd10);
    chk("rstmid_frame_valid", 32'(m_valid), 32'd1);
    chk("rstmid_frame_data",  32'(m_data),  32'h000);
    step();

    // Reset with a pending vector
    m_ready = 1'b0;
    send5(8'd200, 8'd200, 8'd200, 8'd200, 8'd200);
    chk("rstpend_pre", 32'(m_data), 32'h3FF);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rstpend_valid", 32'(m_valid), 32'd0);
    chk("rstpend_data",  32'(m_data),  32'h0);
    chk("stat_frames_rst", 32'(stat_frames), 32'd0);
    chk("stat_errs_rst",   32'(stat_errs),   32'd0);
    m_ready = 1'b1;

    // One bad and one good frame
    send(8'd1, 1'b1);
    chk("bad_err", 32'(err), 32'd1);
    send5(8'd10, 8'd64, 8'd127, 8'd200, 8'd255);
    chk("post_rst_data", 32'(m_data), 32'h3D4);
    step();
`ifdef TNN_PACKER_STATS_EN
    chk("stat_frames", 32'(stat_frames), 32'd1);
    chk("stat_errs",   32'(stat_errs),   32'd1);
`else
    chk("stat_frames", 32'(stat_frames), 32'd0);
    chk("stat_errs",   32'(stat_errs),   32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
